// File: rtl/aoi_response_checker.sv
// Response checker for an AOI22 gate, e = ~((a & b) | (c & d)).
// Counts mismatches, tracks input-vector coverage and records the first failing vector per run.
module aoi_response_checker #(
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_vec,
    input  logic             in_e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      cov_mask,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);
    // state | meaning
    // IDLE  | after reset, waiting for start
    // RUN   | accepting samples until NUM_SAMPLES have been seen
    // DONE  | verdict held until start or rst
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0]      LAST_IDX = 16'(NUM_SAMPLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    logic [15:0]      sample_cnt;
    logic             expected;
    logic             accept;
    logic             mismatch;
    logic             last;
    logic [ERR_W-1:0] err_next;
    logic [15:0]      cov_next;

    always_comb begin
        expected = ~((in_vec[3] & in_vec[2]) | (in_vec[1] & in_vec[0]));
        accept   = (state == RUN) && in_valid;
        mismatch = accept && (in_e != expected);
        last     = accept && (sample_cnt == LAST_IDX);
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX))
            err_next = err_count + 1'b1;
        cov_next = cov_mask;
        if (accept)
            cov_next = cov_mask | (16'd1 << in_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            cov_mask        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            sample_cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        cov_mask        <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        sample_cnt      <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        err_count  <= err_next;
                        cov_mask   <= cov_next;
                        sample_cnt <= sample_cnt + 16'd1;
                        if (mismatch && !first_err_valid) begin
                            first_err_vec   <= in_vec;
                            first_err_valid <= 1'b1;
                        end
                    end
                    // verdict uses the post-update values so the last sample counts
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0) && (cov_next == 16'hFFFF);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aoi_response_checker.sv
// Bench for aoi_response_checker: two instances (16 and 300 samples) share stimulus
// and are compared every cycle against a behavioural model of a checking run.
module tb_aoi_response_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_e = 1'b0;
    logic [3:0] in_vec = 4'd0;

    logic        busy_a, done_a, pass_a, fev_ok_a;
    logic [7:0]  err_a;
    logic [15:0] cov_a;
    logic [3:0]  fev_a;
    logic        busy_b, done_b, pass_b, fev_ok_b;
    logic [7:0]  err_b;
    logic [15:0] cov_b;
    logic [3:0]  fev_b;

    aoi_response_checker #(.NUM_SAMPLES(16), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec), .in_e(in_e),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .cov_mask(cov_a),
        .first_err_vec(fev_a), .first_err_valid(fev_ok_a));

    aoi_response_checker #(.NUM_SAMPLES(300), .ERR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec), .in_e(in_e),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .cov_mask(cov_b),
        .first_err_vec(fev_b), .first_err_valid(fev_ok_b));

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit aoi_ref(input logic [3:0] v);
        return !((v[3] && v[2]) || (v[1] && v[0]));
    endfunction

    // model of one run per instance: unsaturated error tally, coverage set, first bad vector
    int          lim[2] = '{16, 300};
    bit          m_run[2], m_done[2];
    int          m_cnt[2], m_errs[2], m_first[2];
    logic [15:0] m_cov[2];

    task automatic model_clear(input int k);
        m_cnt[k] = 0; m_errs[k] = 0; m_first[k] = -1; m_cov[k] = 16'd0;
    endtask

    task automatic model_update(input int k, input bit r, input bit s, input bit v,
                                input logic [3:0] vec, input bit e);
        if (r) begin
            m_run[k] = 0; m_done[k] = 0; model_clear(k);
        end else if (!m_run[k] && s) begin
            m_run[k] = 1; m_done[k] = 0; model_clear(k);
        end else if (m_run[k] && v) begin
            m_cnt[k]++;
            m_cov[k][vec] = 1'b1;
            if (e != aoi_ref(vec)) begin
                m_errs[k]++;
                if (m_first[k] < 0) m_first[k] = int'(vec);
            end
            if (m_cnt[k] == lim[k]) begin
                m_run[k] = 0; m_done[k] = 1;
            end
        end
    endtask

    task automatic check_dut(input int k);
        logic [31:0] o_busy, o_done, o_pass, o_err, o_cov, o_fev, o_fok;
        int exp_err;
        bit exp_pass;
        if (k == 0) begin
            o_busy = 32'(busy_a); o_done = 32'(done_a); o_pass = 32'(pass_a);
            o_err = 32'(err_a); o_cov = 32'(cov_a); o_fev = 32'(fev_a); o_fok = 32'(fev_ok_a);
        end else begin
            o_busy = 32'(busy_b); o_done = 32'(done_b); o_pass = 32'(pass_b);
            o_err = 32'(err_b); o_cov = 32'(cov_b); o_fev = 32'(fev_b); o_fok = 32'(fev_ok_b);
        end
        exp_err  = (m_errs[k] > 255) ? 255 : m_errs[k];
        exp_pass = m_done[k] && (m_errs[k] == 0) && (m_cov[k] == 16'hFFFF);
        check_val($sformatf("d%0d_busy", k), o_busy, 32'(m_run[k]));
        check_val($sformatf("d%0d_done", k), o_done, 32'(m_done[k]));
        check_val($sformatf("d%0d_pass", k), o_pass, 32'(exp_pass));
        check_val($sformatf("d%0d_err", k), o_err, 32'(exp_err));
        check_val($sformatf("d%0d_cov", k), o_cov, 32'(m_cov[k]));
        check_val($sformatf("d%0d_fev", k), o_fev, (m_first[k] < 0) ? 32'd0 : 32'(m_first[k]));
        check_val($sformatf("d%0d_fev_ok", k), o_fok, 32'(m_first[k] >= 0));
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [3:0] vec, input bit e);
        @(negedge clk);
        rst = r; start = s; in_valid = v; in_vec = vec; in_e = e;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k, r, s, v, vec, e);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_done[k] = 0; model_clear(k);
        end

        step(1, 1, 1, 4'd5, 1'b0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_err", 32'(err_a), 32'd0);

        // full sweep, all responses correct
        step(0, 1, 0, 4'd0, 1'b0);
        for (int v = 0; v < 16; v++) step(0, 0, 1, 4'(v), aoi_ref(4'(v)));
        check_val("sweep_done", 32'(done_a), 32'd1);
        check_val("sweep_pass", 32'(pass_a), 32'd1);
        check_val("sweep_cov", 32'(cov_a), 32'hFFFF);
        check_val("sweep_fev_ok", 32'(fev_ok_a), 32'd0);
        step(0, 0, 1, 4'd3, 1'b0);
        check_val("done_hold_pass", 32'(pass_a), 32'd1);

        // descending sweep with faults at 1100 and 0011
        step(0, 1, 0, 4'd0, 1'b0);
        for (int v = 15; v >= 0; v--)
            step(0, 0, 1, 4'(v), aoi_ref(4'(v)) ^ ((v == 12) || (v == 3)));
        check_val("two_err_cnt", 32'(err_a), 32'd2);
        check_val("two_err_fev", 32'(fev_a), 32'hC);
        check_val("two_err_fev_ok", 32'(fev_ok_a), 32'd1);
        check_val("two_err_pass", 32'(pass_a), 32'd0);

        // correct but incomplete coverage
        step(0, 1, 0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 4'd0, 1'b1);
        check_val("cov0_done", 32'(done_a), 32'd1);
        check_val("cov0_cov", 32'(cov_a), 32'h0001);
        check_val("cov0_pass", 32'(pass_a), 32'd0);

        // saturation on the 300-sample instance
        step(1, 0, 0, 4'd0, 1'b0);
        step(0, 1, 0, 4'd0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            step(0, 0, 1, v, !aoi_ref(v));
        end
        check_val("sat_done", 32'(done_b), 32'd1);
        check_val("sat_err", 32'(err_b), 32'd255);
        check_val("sat_pass", 32'(pass_b), 32'd0);

        // reset mid-run, then stray valids without start
        step(0, 1, 0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 4'(i), 1'b0);
        step(1, 0, 1, 4'd9, 1'b0);
        check_val("abort_busy", 32'(busy_a), 32'd0);
        check_val("abort_cov", 32'(cov_a), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(i + 8), 1'b0);
        check_val("stray_err", 32'(err_a), 32'd0);
        check_val("stray_cov", 32'(cov_a), 32'd0);

        // gapped samples with start pulses during RUN
        step(0, 1, 0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(0, (i % 4) == 1, 1, 4'(i), (i == 6) ? !aoi_ref(4'(i)) : aoi_ref(4'(i)));
            if (i < 15) begin
                step(0, 1, 0, 4'd0, 1'b0);
                check_val("gap_not_done", 32'(done_a), 32'd0);
            end
        end
        check_val("gap_done", 32'(done_a), 32'd1);
        check_val("gap_err", 32'(err_a), 32'd1);
        check_val("gap_fev", 32'(fev_a), 32'd6);
        step(0, 1, 1, 4'd7, 1'b0);
        check_val("restart_busy", 32'(busy_a), 32'd1);
        check_val("restart_err", 32'(err_a), 32'd0);
        check_val("restart_cov", 32'(cov_a), 32'd0);

        // random traffic, model-checked every cycle
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                 v, aoi_ref(v) ^ ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
